ack_bus_rr_arbiter: RTL



---
 rtl/ack_bus_pkg.sv | 22 ++
 rtl/ack_prio_pick.sv | 36 +++
 rtl/ack_bus_rr_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ack_bus_pkg.sv
// Shared types and constants for the ACK bus arbiter slice.
// Latency: n/a (declarations only); backpressure: n/a.
package ack_bus_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_FIXED   = 0;
    localparam int ARB_RR      = 1;

    localparam int NUM_SRC_DEF = 4;

    // Source IDs of the original 4-source ACK bus, kept so that legacy
    // integration code can name requesters symbolically.
    localparam int ID_MEM  = 0;
    localparam int ID_SHA  = 1;
    localparam int ID_AES  = 2;
    localparam int ID_CTRL = 3;

endpackage

// File: rtl/ack_prio_pick.sv
// Rotating priority picker: first set request at or above start, wrapping.
// Latency: combinational; backpressure: none (pure function of inputs).
module ack_prio_pick
    import ack_bus_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic               found,
    output logic [ID_W-1:0]    winner
);

    // Modulo add that also works when NUM_SRC is not a power of two.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end
        return ID_W'(sum);
    endfunction

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && req[wrap_add(start, i)]) begin
                found  = 1'b1;
                winner = wrap_add(start, i);
            end
        end
    end

endmodule

// File: rtl/ack_bus_rr_arbiter.sv
// Shared ACK channel arbiter: registered one-hot grant held until done, abort or timeout.
// Latency: grant 1 cycle after req sampled in IDLE; backpressure: no preemption, one IDLE bubble between grants.
module ack_bus_rr_arbiter
    import ack_bus_pkg::*;
#(
    parameter int NUM_SRC  = NUM_SRC_DEF,
    parameter int ID_W     = $clog2(NUM_SRC),
    parameter int RR_MODE  = ARB_FIXED,
    parameter int HOLD_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] ack_done,
    output logic [NUM_SRC-1:0] ack_ready,
    output logic               grant_valid,
    output logic [ID_W-1:0]    winner_source_id,
    output logic               ack_event,
    output logic [ID_W-1:0]    ack_id,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [NUM_SRC-1:0] ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

    arb_state_t         state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    win_q, win_d;
    logic               event_q, event_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               to_q, to_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    start_q, start_d;

    logic [ID_W-1:0]    pick_start;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic               cur_done;
    logic               cur_req;
    logic               hold_expired;
    logic [ID_W-1:0]    win_next;

    // Fixed mode always searches from index 0, mirroring wired-AND bus priority.
    assign pick_start = (RR_MODE == ARB_RR) ? start_q : '0;

    ack_prio_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req),
        .start  (pick_start),
        .found  (pick_found),
        .winner (pick_idx)
    );

    assign cur_done     = ack_done[win_q];
    assign cur_req      = req[win_q];
    assign hold_expired = (HOLD_MAX != 0) && (cnt_q == HOLD_LAST);
    assign win_next     = (int'(win_q) == NUM_SRC - 1) ? '0 : win_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            win_q   <= '0;
            event_q <= 1'b0;
            id_q    <= '0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            start_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            win_q   <= win_d;
            event_q <= event_d;
            id_q    <= id_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        win_d   = win_q;
        event_d = 1'b0;
        id_d    = id_q;
        to_d    = 1'b0;
        cnt_d   = cnt_q;
        start_d = start_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    grant_d = ONE_HOT0 << pick_idx;
                    win_d   = pick_idx;
                    cnt_d   = '0;
                end
            end

            ST_GRANT: begin
                if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Completion beats both abort and timeout; abort beats timeout.
                if (cur_done || !cur_req || hold_expired) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    start_d = win_next;
                    if (cur_done) begin
                        event_d = 1'b1;
                        id_d    = win_q;
                    end else if (cur_req) begin
                        to_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign ack_ready        = grant_q;
    assign grant_valid      = |grant_q;
    assign winner_source_id = win_q;
    assign ack_event        = event_q;
    assign ack_id           = id_q;
    assign timeout          = to_q;

endmodule
